systolic_mult_arbiter: RTL and testbench
========================================

Name: systolic_mult_arbiter

Overview:
Round-robin arbiter and sequencer that shares one sequential `mult` unit (start/busy handshake) among NUM_PE systolic processing elements. It sits between the PE array and a single `mult` instance. It replaces per-PE multipliers and free-running count-based start generation with an explicit request/done handshake. Each grant launches one multiply, waits for `mult` completion, and returns the product to the granted PE.

Parameters:
- WORDLENGTH, 16, operand and product width (matches `mult` I/O).
- NUM_PE, 8, number of requesting PEs.
- IDX_W, 3, width of PE index; must satisfy 2^IDX_W >= NUM_PE.
- TIMEOUT_CYCLES, 64, watchdog limit; used only with MULT_ARB_TIMEOUT_EN.

Ports:
- clk30x  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  NUM_PE  level request per PE; held until that PE's done pulse.
- opa_bus  in  NUM_PE*WORDLENGTH  flattened operand A, PE i at bits [i*WORDLENGTH +: WORDLENGTH].
- opb_bus  in  NUM_PE*WORDLENGTH  flattened operand B (coefficient), same packing.
- grant  out  NUM_PE  one-hot; PE currently owning the multiplier.
- done  out  NUM_PE  one-cycle pulse to the granted PE when result is valid.
- result  out  WORDLENGTH  product; valid in the done cycle, held until the next done.
- arb_busy  out  1  high in every state except IDLE.
- timeout_err  out  1  one-cycle pulse on watchdog expiry (tied 0 without the macro).
- mult_start  out  1  one-cycle start pulse to `mult`.
- mult_a  out  WORDLENGTH  registered operand A to `mult`.
- mult_b  out  WORDLENGTH  registered operand B to `mult`.
- mult_busy  in  1  `mult` busy flag.
- mult_product  in  WORDLENGTH  `mult` product, valid when mult_busy falls.

Behaviour:
- Reset (async, reset=0):
  - state=IDLE, rr_ptr=0, grant=0, done=0, result=0, mult_a=mult_b=0, mult_start=0, arb_busy=0, timeout_err=0.
  - Reset asserted mid-operation aborts immediately. No done is issued. The `mult` in-flight result is ignored.
- FSM transitions:
  - IDLE: if req!=0, select the first set req bit scanning rr_ptr, rr_ptr+1, … modulo NUM_PE. Latch its operands into mult_a/mult_b, set grant one-hot, go START. Otherwise stay.
  - START: mult_start=1 for exactly this cycle, go WAIT_BUSY.
  - WAIT_BUSY: stay until mult_busy=1, then go WAIT_DONE.
  - WAIT_DONE: stay while mult_busy=1. On mult_busy=0, register result<=mult_product and go DONE.
  - DONE: done[grant_idx]=1 for one cycle, rr_ptr<=(grant_idx+1) mod NUM_PE, grant<=0, go IDLE.
- Latency: req seen in IDLE at cycle 0 gives mult_start at cycle 1. Done occurs at cycle 3+B, where B is the number of cycles mult_busy is high (rises cycle 2 → done cycle 3+B).
- Minimum spacing between consecutive grants is one IDLE cycle. A PE still requesting after its done is re-eligible but lowest priority.
- req deasserted mid-operation: the operation still completes and done still pulses; the PE ignores it.
- Operand change while granted has no effect, because operands are latched in IDLE.
- rr_ptr wraps from NUM_PE-1 to 0.
- Non-power-of-two NUM_PE: indices >= NUM_PE are never selected.

Optional Feature:
- MULT_ARB_TIMEOUT_EN defined:
  - A cycle counter clears on entering WAIT_BUSY and counts in WAIT_BUSY and WAIT_DONE.
  - When it reaches TIMEOUT_CYCLES: go DONE with result=0, pulse timeout_err together with done, and advance rr_ptr normally.
- Undefined: no counter, the FSM waits indefinitely, timeout_err is constant 0, and TIMEOUT_CYCLES is unused.

Test Plan:
- Single request: req=8'b0000_0100, opa=3, opb=5, `mult` model with B=4 → mult_start one cycle at t=1, done[2] at t=7, result=15, grant=0 afterwards.
- Simultaneous requests: req=8'b1000_0001 after reset → PE0 served first, then PE7. PE7's done follows PE0's done after 1 IDLE + 3+B cycles.
- Fairness: all 8 req held high for 16 operations → grant order 0,1,…,7,0,…,7, each PE done exactly twice.
- Request withdrawn: PE3 drops req in WAIT_DONE → done[3] still pulses, next grant goes to the next requester after PE3.
- Async reset asserted during WAIT_DONE: all outputs 0 immediately, no done. After release, a held req restarts from PE0 priority.
- With MULT_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=10, `mult` never raises busy → done and timeout_err pulse together 10 cycles after entering WAIT_BUSY, result=0.

Source files
------------

// File: rtl/systolic_mult_arbiter_if.sv
// -----------------------------------------------------------------------------
// systolic_mult_arbiter_if
// Bundle of every signal between the systolic_mult_arbiter, the PE array and
// the shared sequential `mult` unit.
//   PE side   : req, opa_bus, opb_bus (to arbiter); grant, done, result,
//               arb_busy, timeout_err (from arbiter)
//   mult side : mult_start, mult_a, mult_b (from arbiter);
//               mult_busy, mult_product (to arbiter)
// Modports:
//   slave  - the arbiter's view
//   master - the environment's view (PE array plus `mult`)
// -----------------------------------------------------------------------------
interface systolic_mult_arbiter_if #(
    parameter int WORDLENGTH = 16,
    parameter int NUM_PE     = 8
);
    logic [NUM_PE-1:0]            req;
    logic [NUM_PE*WORDLENGTH-1:0] opa_bus;
    logic [NUM_PE*WORDLENGTH-1:0] opb_bus;
    logic [NUM_PE-1:0]            grant;
    logic [NUM_PE-1:0]            done;
    logic [WORDLENGTH-1:0]        result;
    logic                         arb_busy;
    logic                         timeout_err;
    logic                         mult_start;
    logic [WORDLENGTH-1:0]        mult_a;
    logic [WORDLENGTH-1:0]        mult_b;
    logic                         mult_busy;
    logic [WORDLENGTH-1:0]        mult_product;

    modport slave (
        input  req, opa_bus, opb_bus, mult_busy, mult_product,
        output grant, done, result, arb_busy, timeout_err,
               mult_start, mult_a, mult_b
    );

    modport master (
        output req, opa_bus, opb_bus, mult_busy, mult_product,
        input  grant, done, result, arb_busy, timeout_err,
               mult_start, mult_a, mult_b
    );
endinterface

// File: rtl/systolic_mult_arbiter.sv
// -----------------------------------------------------------------------------
// systolic_mult_arbiter
// Round-robin arbiter/sequencer sharing one sequential `mult` unit among
// NUM_PE processing elements. Each grant latches the winner's operands,
// pulses mult_start, waits for mult_busy to rise and fall, then returns the
// product to the granted PE with a one-cycle done pulse.
// Ports:
//   clk30x - system clock, all state on the rising edge
//   reset  - asynchronous active-low reset
//   bus    - systolic_mult_arbiter_if.slave (PE request/grant/done/result,
//            arb_busy, timeout_err, and the mult start/busy handshake)
// Optional build macro:
//   MULT_ARB_TIMEOUT_EN - adds a watchdog; after TIMEOUT_CYCLES cycles in
//   WAIT_BUSY/WAIT_DONE the operation ends with result 0, done and
//   timeout_err pulsing together. Without it timeout_err is constant 0.
// -----------------------------------------------------------------------------
module systolic_mult_arbiter #(
    parameter int WORDLENGTH     = 16,
    parameter int NUM_PE         = 8,
    parameter int IDX_W          = 3,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                    clk30x,
    input  logic                    reset,
    systolic_mult_arbiter_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_DONE
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PE - 1);

    state_t                state_q;
    logic [IDX_W-1:0]      rr_ptr_q;
    logic [IDX_W-1:0]      grant_idx_q;
    logic [NUM_PE-1:0]     grant_q;
    logic [NUM_PE-1:0]     done_q;
    logic [WORDLENGTH-1:0] result_q;
    logic [WORDLENGTH-1:0] mult_a_q;
    logic [WORDLENGTH-1:0] mult_b_q;
    logic                  mult_start_q;

    logic                  sel_found_d;
    logic [IDX_W-1:0]      sel_idx_d;
    logic [NUM_PE-1:0]     sel_onehot_d;
    logic [WORDLENGTH-1:0] sel_a_d;
    logic [WORDLENGTH-1:0] sel_b_d;
    logic [IDX_W-1:0]      rr_ptr_d;

`ifdef MULT_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0]      tmo_cnt_q;
    logic                  timeout_err_q;
`endif

    // Round-robin pick: scan from the far end back toward rr_ptr so the
    // requester closest to rr_ptr is the last (winning) assignment. Only
    // indices below NUM_PE are ever produced.
    always_comb begin
        int j;
        j           = 0;
        sel_found_d = 1'b0;
        sel_idx_d   = '0;
        for (int k = NUM_PE - 1; k >= 0; k--) begin
            j = int'(rr_ptr_q) + k;
            if (j >= NUM_PE) j = j - NUM_PE;
            if (bus.req[j]) begin
                sel_found_d = 1'b1;
                sel_idx_d   = IDX_W'(j);
            end
        end
        sel_onehot_d            = '0;
        sel_onehot_d[sel_idx_d] = 1'b1;
        sel_a_d = bus.opa_bus[sel_idx_d*WORDLENGTH +: WORDLENGTH];
        sel_b_d = bus.opb_bus[sel_idx_d*WORDLENGTH +: WORDLENGTH];
        rr_ptr_d = (grant_idx_q == LAST_IDX) ? '0 : grant_idx_q + IDX_W'(1);
    end

    // done, mult_start and timeout_err default low each cycle so every one
    // of them is a single-cycle pulse set by the transition that needs it.
    always_ff @(posedge clk30x or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            rr_ptr_q      <= '0;
            grant_idx_q   <= '0;
            grant_q       <= '0;
            done_q        <= '0;
            result_q      <= '0;
            mult_a_q      <= '0;
            mult_b_q      <= '0;
            mult_start_q  <= 1'b0;
`ifdef MULT_ARB_TIMEOUT_EN
            tmo_cnt_q     <= '0;
            timeout_err_q <= 1'b0;
`endif
        end else begin
            done_q       <= '0;
            mult_start_q <= 1'b0;
`ifdef MULT_ARB_TIMEOUT_EN
            timeout_err_q <= 1'b0;
`endif
            case (state_q)
                S_IDLE: begin
                    if (sel_found_d) begin
                        mult_a_q     <= sel_a_d;
                        mult_b_q     <= sel_b_d;
                        grant_q      <= sel_onehot_d;
                        grant_idx_q  <= sel_idx_d;
                        mult_start_q <= 1'b1;
                        state_q      <= S_START;
                    end
                end
                S_START: begin
`ifdef MULT_ARB_TIMEOUT_EN
                    tmo_cnt_q <= '0;
`endif
                    state_q <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    if (bus.mult_busy) begin
                        state_q <= S_WAIT_DONE;
                    end
`ifdef MULT_ARB_TIMEOUT_EN
                    else if (tmo_cnt_q == CNT_LAST) begin
                        result_q      <= '0;
                        done_q        <= grant_q;
                        timeout_err_q <= 1'b1;
                        state_q       <= S_DONE;
                    end
                    tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
`endif
                end
                S_WAIT_DONE: begin
                    // A genuine completion wins over a same-cycle timeout.
                    if (!bus.mult_busy) begin
                        result_q <= bus.mult_product;
                        done_q   <= grant_q;
                        state_q  <= S_DONE;
                    end
`ifdef MULT_ARB_TIMEOUT_EN
                    else if (tmo_cnt_q == CNT_LAST) begin
                        result_q      <= '0;
                        done_q        <= grant_q;
                        timeout_err_q <= 1'b1;
                        state_q       <= S_DONE;
                    end
                    tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
`endif
                end
                S_DONE: begin
                    rr_ptr_q <= rr_ptr_d;
                    grant_q  <= '0;
                    state_q  <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.grant      = grant_q;
    assign bus.done       = done_q;
    assign bus.result     = result_q;
    assign bus.mult_start = mult_start_q;
    assign bus.mult_a     = mult_a_q;
    assign bus.mult_b     = mult_b_q;
    assign bus.arb_busy   = (state_q != S_IDLE);
`ifdef MULT_ARB_TIMEOUT_EN
    assign bus.timeout_err = timeout_err_q;
`else
    assign bus.timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_systolic_mult_arbiter.sv
module tb_systolic_mult_arbiter;
    localparam int W   = 16;
    localparam int N   = 8;
    localparam int IW  = 3;
    localparam int TMO = 64;

    logic clk30x = 1'b0;
    logic reset  = 1'b0;
    always #5 clk30x = ~clk30x;

    systolic_mult_arbiter_if #(.WORDLENGTH(W), .NUM_PE(N)) bus_if ();

    systolic_mult_arbiter #(
        .WORDLENGTH(W), .NUM_PE(N), .IDX_W(IW), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk30x (clk30x),
        .reset  (reset),
        .bus    (bus_if)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural `mult`: start at a clock edge raises busy for `lat` cycles;
    // the truncated product is presented from the start edge onward.
    int         fixed_lat  = 4;
    bit         rand_lat   = 1'b0;
    bit         never_busy = 1'b0;
    int         busy_cnt   = 0;
    logic [W-1:0] prod_q   = '0;

    function automatic int pick_lat();
        if (never_busy) return 0;
        if (rand_lat)   return int'($urandom_range(1, 6));
        return fixed_lat;
    endfunction

    always @(posedge clk30x) begin
        if (!reset) begin
            busy_cnt <= 0;
        end else if (bus_if.mult_start) begin
            busy_cnt <= pick_lat();
            prod_q   <= bus_if.mult_a * bus_if.mult_b;
        end else if (busy_cnt > 0) begin
            busy_cnt <= busy_cnt - 1;
        end
    end
    assign bus_if.mult_busy    = (busy_cnt != 0);
    assign bus_if.mult_product = prod_q;

    int cyc = 0;
    always @(posedge clk30x) cyc <= cyc + 1;

    // Transaction-level reference: round-robin pick by modular scan, product
    // taken from the operands present in the idle decision cycle.
    function automatic int first_req(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++)
            if (r[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    typedef struct {
        int           idx;
        logic [W-1:0] prod;
        int           gcyc;
    } pend_t;
    pend_t pq[$];

    bit             mon_en = 1'b1;
    int             m_ptr  = 0;
    bit             p_valid = 1'b0;
    bit             p_idle  = 1'b0;
    logic [N-1:0]   p_req;
    logic [N*W-1:0] p_opa, p_opb;
    int             busy_cycles = 0;

    task automatic monitor_step();
        int    ei;
        pend_t e;
        logic [31:0] full;
        logic [N-1:0] eg;
        if (!reset || !mon_en) begin
            pq.delete();
            m_ptr = 0; p_valid = 1'b0; busy_cycles = 0;
            return;
        end
        if (p_valid && p_idle) begin
            ei = first_req(p_req, m_ptr);
            eg = '0;
            if (ei >= 0) eg[ei] = 1'b1;
            check("grant_select", 32'(bus_if.grant), 32'(eg));
            if (ei >= 0) begin
                full   = 32'(p_opa[ei*W +: W]) * 32'(p_opb[ei*W +: W]);
                e.idx  = ei;
                e.prod = full[W-1:0];
                e.gcyc = cyc;
                pq.push_back(e);
                busy_cycles = 0;
            end
        end
        if (bus_if.mult_busy) busy_cycles++;
        if (bus_if.done != '0) begin
            if (pq.size() == 0) begin
                check("done_unexpected", 32'(bus_if.done), 32'd0);
            end else begin
                e  = pq.pop_front();
                eg = '0;
                eg[e.idx] = 1'b1;
                check("done_onehot", 32'(bus_if.done), 32'(eg));
                check("result", 32'(bus_if.result), 32'(e.prod));
                check("done_latency", 32'(cyc - e.gcyc), 32'(2 + busy_cycles));
                check("timeout_err_low", 32'(bus_if.timeout_err), 32'd0);
                m_ptr = (e.idx + 1) % N;
            end
        end
        p_valid = 1'b1;
        p_idle  = !bus_if.arb_busy;
        p_req   = bus_if.req;
        p_opa   = bus_if.opa_bus;
        p_opb   = bus_if.opb_bus;
    endtask

    always @(negedge clk30x) monitor_step();

    task automatic set_ops(input logic [W-1:0] a, input logic [W-1:0] b);
        for (int i = 0; i < N; i++) begin
            bus_if.opa_bus[i*W +: W] = a;
            bus_if.opb_bus[i*W +: W] = b;
        end
    endtask

    task automatic wait_done(input int limit, output int k, output logic [N-1:0] d);
        k = -1;
        d = '0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk30x);
            if (bus_if.done != '0) begin
                d = bus_if.done;
                k = i;
                return;
            end
        end
        check("wait_done_bound", 32'd0, 32'd1);
    endtask

    task automatic reset_pulse();
        @(posedge clk30x); #1;
        reset = 1'b0;
        repeat (2) @(posedge clk30x);
        #1 reset = 1'b1;
    endtask

    typedef struct {
        logic [N-1:0] req;
        logic [W-1:0] a;
        logic [W-1:0] b;
        int           lat;
        int           exp_idx;
        logic [W-1:0] exp_res;
    } vec_t;
    vec_t vt[7];

    initial begin
        #1_000_000;
        $display("FAIL global_watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int           k, ms_k, ms_n, last_k;
        logic [N-1:0] d;
        int           cnt[N];

        vt[0] = '{8'h04, 16'd3,     16'd5,      4, 2, 16'd15};
        vt[1] = '{8'h81, 16'd7,     16'd9,      4, 7, 16'd63};
        vt[2] = '{8'h81, 16'd7,     16'd9,      2, 0, 16'd63};
        vt[3] = '{8'hFF, 16'd100,   16'd3,      3, 1, 16'd300};
        vt[4] = '{8'h01, 16'h1234,  16'h0010,   1, 0, 16'h2340};
        vt[5] = '{8'h80, 16'hFFFF,  16'h0002,   5, 7, 16'hFFFE};
        vt[6] = '{8'hFE, 16'h00FF,  16'h0101,   2, 1, 16'hFFFF};

        bus_if.req = '0;
        set_ops('0, '0);
        repeat (3) @(posedge clk30x);
        #1;
        check("rst_grant",      32'(bus_if.grant), 32'd0);
        check("rst_done",       32'(bus_if.done), 32'd0);
        check("rst_result",     32'(bus_if.result), 32'd0);
        check("rst_mult_a",     32'(bus_if.mult_a), 32'd0);
        check("rst_mult_b",     32'(bus_if.mult_b), 32'd0);
        check("rst_mult_start", 32'(bus_if.mult_start), 32'd0);
        check("rst_arb_busy",   32'(bus_if.arb_busy), 32'd0);
        check("rst_timeout",    32'(bus_if.timeout_err), 32'd0);
        reset = 1'b1;

        // Table-driven single transactions, round-robin pointer carried over.
        for (int v = 0; v < 7; v++) begin
            @(posedge clk30x); #1;
            set_ops(vt[v].a, vt[v].b);
            fixed_lat  = vt[v].lat;
            bus_if.req = vt[v].req;
            ms_k = -1; ms_n = 0; k = -1; d = '0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk30x);
                if (bus_if.mult_start) begin
                    ms_n++;
                    if (ms_k < 0) ms_k = i;
                end
                if (bus_if.done != '0) begin
                    k = i; d = bus_if.done;
                    break;
                end
            end
            check($sformatf("tbl%0d_done_seen", v), 32'(k >= 0), 32'd1);
            check($sformatf("tbl%0d_done_idx", v), 32'(d), 32'(1) << vt[v].exp_idx);
            check($sformatf("tbl%0d_result", v), 32'(bus_if.result), 32'(vt[v].exp_res));
            check($sformatf("tbl%0d_latency", v), 32'(k), 32'(3 + vt[v].lat));
            check($sformatf("tbl%0d_start_cycle", v), 32'(ms_k), 32'd1);
            check($sformatf("tbl%0d_start_width", v), 32'(ms_n), 32'd1);
            @(posedge clk30x); #1;
            bus_if.req = '0;
            @(negedge clk30x);
            check($sformatf("tbl%0d_grant_clear", v), 32'(bus_if.grant), 32'd0);
            check($sformatf("tbl%0d_idle", v), 32'(bus_if.arb_busy), 32'd0);
        end

        // Request withdrawn during WAIT_DONE.
        reset_pulse();
        @(posedge clk30x); #1;
        set_ops(16'd5, 16'd6);
        fixed_lat  = 4;
        bus_if.req = 8'h28;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk30x);
            if (bus_if.mult_busy) break;
        end
        @(posedge clk30x); #1;
        bus_if.req = 8'h20;
        wait_done(20, k, d);
        check("withdraw_done3", 32'(d), 32'h08);
        check("withdraw_result", 32'(bus_if.result), 32'd30);
        wait_done(30, k, d);
        check("withdraw_next_pe5", 32'(d), 32'h20);
        @(posedge clk30x); #1;
        bus_if.req = '0;

        // Asynchronous reset during WAIT_DONE aborts with no done.
        @(posedge clk30x); #1;
        fixed_lat  = 6;
        bus_if.req = 8'h10;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk30x);
            if (bus_if.mult_busy) break;
        end
        @(posedge clk30x); #3;
        check("abort_pre_busy", 32'(bus_if.arb_busy), 32'd1);
        reset = 1'b0;
        #1;
        check("abort_grant",    32'(bus_if.grant), 32'd0);
        check("abort_done",     32'(bus_if.done), 32'd0);
        check("abort_arb_busy", 32'(bus_if.arb_busy), 32'd0);
        check("abort_start",    32'(bus_if.mult_start), 32'd0);
        check("abort_result",   32'(bus_if.result), 32'd0);
        check("abort_mult_a",   32'(bus_if.mult_a), 32'd0);
        bus_if.req = 8'h81;
        set_ops(16'd3, 16'd4);
        fixed_lat  = 2;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk30x);
            check("abort_no_done", 32'(bus_if.done), 32'd0);
        end
        @(posedge clk30x); #1;
        reset = 1'b1;
        wait_done(30, k, d);
        check("abort_restart_pe0", 32'(d), 32'h01);
        check("abort_restart_res", 32'(bus_if.result), 32'd12);
        @(posedge clk30x); #1;
        bus_if.req = '0;

        // Fairness: all PEs requesting continuously for 16 operations.
        reset_pulse();
        foreach (cnt[i]) cnt[i] = 0;
        fixed_lat = 3;
        set_ops(16'd2, 16'd11);
        @(posedge clk30x); #1;
        bus_if.req = 8'hFF;
        last_k = 0;
        for (int n = 0; n < 16; n++) begin
            wait_done(30, k, d);
            check($sformatf("fair_order%0d", n), 32'(d), 32'(1) << (n % N));
            if (n > 0) check($sformatf("fair_spacing%0d", n), 32'(k + 1), 32'(4 + 3));
            for (int i = 0; i < N; i++) if (d[i]) cnt[i]++;
        end
        for (int i = 0; i < N; i++) check($sformatf("fair_count_pe%0d", i), 32'(cnt[i]), 32'd2);
        @(posedge clk30x); #1;
        bus_if.req = '0;
        repeat (3) @(posedge clk30x);

        // Randomised traffic checked by the reference monitor.
        rand_lat = 1'b1;
        for (int c = 0; c < 2500; c++) begin
            @(posedge clk30x); #1;
            if ($urandom_range(0, 3) == 0) bus_if.req = N'($urandom);
            bus_if.opa_bus = {$urandom, $urandom, $urandom, $urandom};
            bus_if.opb_bus = {$urandom, $urandom, $urandom, $urandom};
        end
        bus_if.req = '0;
        repeat (20) @(posedge clk30x);
        #1;
        check("random_drain", 32'(pq.size()), 32'd0);
        check("random_idle", 32'(bus_if.arb_busy), 32'd0);
        rand_lat = 1'b0;

`ifdef MULT_ARB_TIMEOUT_EN
        // Watchdog: mult never raises busy.
        mon_en = 1'b0;
        reset_pulse();
        never_busy = 1'b1;
        @(posedge clk30x); #1;
        bus_if.req = 8'h01;
        wait_done(TMO + 20, k, d);
        check("tmo_done", 32'(d), 32'h01);
        check("tmo_err", 32'(bus_if.timeout_err), 32'd1);
        check("tmo_result", 32'(bus_if.result), 32'd0);
        check("tmo_latency", 32'(k), 32'(2 + TMO));
        @(posedge clk30x); #1;
        bus_if.req = '0;
        @(negedge clk30x);
        check("tmo_err_pulse", 32'(bus_if.timeout_err), 32'd0);
        never_busy = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
